// File: rtl/tt_uart_pkg.sv
// Shared definitions for the TinyTapeout UART transmitter: FSM encoding,
// default bit period and the pin-bit positions on the tile pads.
package tt_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int CLKS_PER_BIT_DEF = 16;

    localparam int TXD_BIT   = 0;
    localparam int BUSY_BIT  = 1;
    localparam int READY_BIT = 2;
    localparam int VALID_BIT = 0;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while a frame is running and
// emits a single-cycle bit_tick on the last cycle of every bit period.
module uart_baud_gen
    import tt_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_p0;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt_p0 <= '0;
        end else if (run) begin
            cnt_p0 <= (cnt_p0 == LAST) ? '0 : cnt_p0 + 1'b1;
        end
    end

    assign bit_tick = run && (cnt_p0 == LAST);

endmodule

// File: rtl/tt_uart_tx.sv
// UART transmitter tile: 8N1 (optionally 8E1) frames on uo_out[0], with
// busy/ready status on the neighbouring output pins.
module tt_uart_tx
    import tt_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    uart_state_t state_p0;
    logic [7:0]  shreg_p0;
    logic        par_p0;
    logic [2:0]  bit_idx_p0;
    logic        txd_p0;
    logic        ready_p0;

    logic tx_valid;
    logic accept;
    logic bit_tick;
    logic unused_ok;

    assign tx_valid  = uio_in[VALID_BIT];
    assign accept    = ready_p0 && ena && tx_valid;
    assign unused_ok = ^uio_in[7:1];

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .run     (state_p0 != IDLE),
        .bit_tick(bit_tick)
    );

    // txd is loaded one bit ahead at each period boundary so the pin is a
    // plain flop output; ready_p0 mirrors state_p0 == IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_p0   <= IDLE;
            shreg_p0   <= '0;
            par_p0     <= 1'b0;
            bit_idx_p0 <= '0;
            txd_p0     <= 1'b1;
            ready_p0   <= 1'b1;
        end else begin
            case (state_p0)
                IDLE: begin
                    if (accept) begin
                        shreg_p0   <= ui_in;
                        par_p0     <= ^ui_in;
                        bit_idx_p0 <= '0;
                        txd_p0     <= 1'b0;
                        ready_p0   <= 1'b0;
                        state_p0   <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        txd_p0   <= shreg_p0[0];
                        shreg_p0 <= {1'b0, shreg_p0[7:1]};
                        state_p0 <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_idx_p0 == 3'd7) begin
                            bit_idx_p0 <= '0;
                            if (PARITY_EN) begin
                                txd_p0   <= par_p0;
                                state_p0 <= PARITY;
                            end else begin
                                txd_p0   <= 1'b1;
                                state_p0 <= STOP;
                            end
                        end else begin
                            bit_idx_p0 <= bit_idx_p0 + 3'd1;
                            txd_p0     <= shreg_p0[0];
                            shreg_p0   <= {1'b0, shreg_p0[7:1]};
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        txd_p0   <= 1'b1;
                        state_p0 <= STOP;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        ready_p0 <= 1'b1;
                        state_p0 <= IDLE;
                    end
                end
                default: begin
                    txd_p0   <= 1'b1;
                    ready_p0 <= 1'b1;
                    state_p0 <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        uo_out            = '0;
        uo_out[TXD_BIT]   = txd_p0;
        uo_out[BUSY_BIT]  = ~ready_p0;
        uo_out[READY_BIT] = ready_p0;
    end

    assign uio_out = '0;
    assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_uart_tx.sv
// Directed bench for tt_uart_tx: per-cycle expected pin values are queued
// when a frame is launched and compared on the falling clock edge.
module tb_tt_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out0, uio_out0, uio_oe0;
    logic [7:0] uo_out1, uio_out1, uio_oe1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] uo;
        bit         sel;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    always #5 clk = ~clk;

    tt_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out0),
        .uio_out(uio_out0),
        .uio_oe (uio_oe0)
    );

    tt_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out1),
        .uio_out(uio_out1),
        .uio_oe (uio_oe1)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(e.sel ? "uo_out_par" : "uo_out", e.sel ? uo_out1 : uo_out0, e.uo);
        end
    end

    task automatic push_idle(input bit sel);
        exp_q.push_back('{8'h05, sel});
    endtask

    // One frame as seen on uo_out: busy=1, ready=0, txd per bit period.
    task automatic push_frame(input logic [7:0] d, input bit par, input bit sel, input int n_max);
        logic [7:0] v[$];
        for (int k = 0; k < 4; k++) v.push_back(8'h02);
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 4; k++) v.push_back(8'h02 | {7'd0, d[i]});
        if (par)
            for (int k = 0; k < 4; k++) v.push_back(8'h02 | {7'd0, ^d});
        for (int k = 0; k < 4; k++) v.push_back(8'h03);
        for (int i = 0; i < v.size() && i < n_max; i++) exp_q.push_back('{v[i], sel});
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $error("FAIL drain_timeout observed=%0d expected=0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_uo_out", uo_out0, 8'h05);
        check("reset_uio_out", uio_out0, 8'h00);
        check("reset_uio_oe", uio_oe0, 8'h00);
        check("reset_uo_out_par", uo_out1, 8'h05);
        rst_n = 1'b1;

        // 0xA5, single-cycle valid, no parity
        @(posedge clk); #1;
        ui_in = 8'hA5; uio_in = 8'h01;
        push_idle(1'b0);
        push_frame(8'hA5, 1'b0, 1'b0, 1000);
        push_idle(1'b0);
        @(posedge clk); #1;
        uio_in = 8'h00;
        wait_drain(60);
        repeat (8) @(posedge clk);
        #1;

        // 0x07 with even parity
        ui_in = 8'h07; uio_in = 8'h01;
        push_idle(1'b1);
        push_frame(8'h07, 1'b1, 1'b1, 1000);
        push_idle(1'b1);
        @(posedge clk); #1;
        uio_in = 8'h00;
        wait_drain(60);
        repeat (4) @(posedge clk);
        #1;

        // valid held: 0x00 then 0xFF, ui_in changes during the first frame
        ui_in = 8'h00; uio_in = 8'h01;
        push_idle(1'b0);
        push_frame(8'h00, 1'b0, 1'b0, 1000);
        push_idle(1'b0);
        push_frame(8'hFF, 1'b0, 1'b0, 1000);
        push_idle(1'b0);
        @(posedge clk); #1;
        ui_in = 8'hFF;
        repeat (41) @(posedge clk);
        #1;
        uio_in = 8'h00;
        wait_drain(100);
        repeat (12) @(posedge clk);
        #1;

        // ena low blocks acceptance
        ena = 1'b0; ui_in = 8'h55; uio_in = 8'h01;
        repeat (4) push_idle(1'b0);
        repeat (2) @(posedge clk);
        #1;
        uio_in = 8'h00;
        wait_drain(10);
        ena = 1'b1;

        // ena dropped during bit 3: frame completes
        ui_in = 8'hC3; uio_in = 8'h01;
        push_idle(1'b0);
        push_frame(8'hC3, 1'b0, 1'b0, 1000);
        push_idle(1'b0);
        @(posedge clk); #1;
        uio_in = 8'h00;
        repeat (18) @(posedge clk);
        #1;
        ena = 1'b0;
        wait_drain(60);
        ena = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        // reset during data bit 5, then 0x3C on the first edge after reset
        ui_in = 8'h96; uio_in = 8'h01;
        push_idle(1'b0);
        push_frame(8'h96, 1'b0, 1'b0, 26);
        @(posedge clk); #1;
        uio_in = 8'h00;
        repeat (25) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; ui_in = 8'h3C; uio_in = 8'h01;
        push_idle(1'b0);
        push_frame(8'h3C, 1'b0, 1'b0, 1000);
        push_idle(1'b0);
        @(posedge clk); #1;
        uio_in = 8'h00;
        wait_drain(80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tt_uart_tx.md
TT_UART_TX -- requirements
Module: tt_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit (legal range 2..4095).
REQ-002 Parameter PARITY_EN, default 0, meaning 1 appends an even-parity bit after the data bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 ena  input  1  design-selected enable; high when the tile is active.
REQ-006 ui_in  input  8  transmit data byte, sampled only at acceptance.
REQ-007 uio_in  input  8  bit 0 = tx_valid start strobe; bits 7:1 ignored.
REQ-008 uo_out  output  8  bit 0 = txd serial line, bit 1 = busy, bit 2 = ready, bits 7:3 = 0.
REQ-009 uio_out  output  8  constant 0.
REQ-010 uio_oe  output  8  constant 8'h00 (all bidirectional pins are inputs).

Function
REQ-011 Acceptance occurs on a rising edge where ready=1, ena=1 and tx_valid=1; ui_in is then latched into an internal shift register.
REQ-012 ready=1 only in state IDLE; busy is the exact inverse of ready.
REQ-013 States: IDLE, START, DATA, PARITY, STOP; transitions IDLE->START on acceptance, START->DATA, DATA->PARITY (PARITY_EN=1) or DATA->STOP (PARITY_EN=0) after bit 7, PARITY->STOP, STOP->IDLE.
REQ-014 Each of START, PARITY and STOP lasts exactly CLKS_PER_BIT cycles; DATA lasts 8*CLKS_PER_BIT cycles.
REQ-015 txd=1 in IDLE and STOP, 0 in START, current data bit LSB-first in DATA, and the XOR of the 8 latched bits in PARITY.
REQ-016 txd goes low on the first edge after acceptance (latency 1 cycle); it is registered and glitch-free.
REQ-017 Frame length is 10*CLKS_PER_BIT cycles (PARITY_EN=0) or 11*CLKS_PER_BIT cycles (PARITY_EN=1), measured from the first low txd cycle to the end of STOP.
REQ-018 After STOP, the block spends at least 1 cycle in IDLE; with tx_valid held high, back-to-back frames are separated by exactly 1 idle-high cycle.
REQ-019 Changes on ui_in or tx_valid while busy=1 are ignored and are not queued.
REQ-020 ena=0 blocks acceptance in IDLE; ena falling mid-frame does not abort the frame, which completes normally.
REQ-021 Bit-period counter counts 0..CLKS_PER_BIT-1 and wraps; bit index counts 0..7; neither counter may advance in IDLE.

Reset
REQ-022 While rst_n=0 at a clock edge: state=IDLE, counters=0, shift register=0, txd=1, ready=1, busy=0.
REQ-023 Reset asserted mid-frame aborts the frame; txd=1 from the edge after reset is sampled, with no partial stop bit.
REQ-024 On the first edge with rst_n=1 and tx_valid=1, a frame may be accepted.

Structure
REQ-025 Shared package tt_uart_pkg holds the state enum, the CLKS_PER_BIT default and the pin-bit index constants (TXD_BIT=0, BUSY_BIT=1, READY_BIT=2, VALID_BIT=0).
REQ-026 The single sub-module uart_baud_gen (bit-period counter emitting a one-cycle bit_tick, cleared on frame start) is instantiated once.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-027 Reset for 2 cycles, then check uo_out=8'h05 (txd=1, ready=1), uio_out=0 and uio_oe=0.
REQ-028 Send ui_in=8'hA5 with a single-cycle valid: txd=0 for 4 cycles, then 1,0,1,0,0,1,0,1 each for 4 cycles, then stop=1 for 4 cycles; busy high for 40 cycles.
REQ-029 PARITY_EN=1 with ui_in=8'h07: the parity bit is 1; the frame is 44 cycles; ready returns after STOP.
REQ-030 Hold tx_valid high with ui_in=8'h00 then 8'hFF: two frames separated by exactly 1 idle-high cycle; an ui_in change during the first frame does not alter its bits.
REQ-031 ena=0 with valid pulsed: no frame is sent; drop ena during bit 3 of the next frame: the frame completes unchanged.
REQ-032 Assert rst_n=0 during DATA bit 5: txd=1 and ready=1 on the next edge; a new frame of 8'h3C then transmits correctly.
